// File: rtl/mon_pkt_pkg.sv
// Shared packet constants, source and FSM encodings for the monitor transmit path.
package mon_pkt_pkg;

  localparam logic [7:0] HDR_MIC = 8'h07;
  localparam logic [7:0] HDR_KBD = 8'h0C;
  localparam logic [7:0] HDR_SND = 8'h03;

  // Enum values double as bit positions in the request/grant vectors.
  typedef enum logic [1:0] {
    SRC_MIC = 2'd0,
    SRC_KBD = 2'd1,
    SRC_SND = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  function automatic src_e onehot_to_src(input logic [2:0] oh);
    src_e s;
    s = SRC_MIC;
    if (oh[SRC_KBD]) s = SRC_KBD;
    if (oh[SRC_SND]) s = SRC_SND;
    return s;
  endfunction

  function automatic logic [7:0] hdr_of(input src_e s);
    logic [7:0] h;
    h = HDR_MIC;
    if (s == SRC_KBD) h = HDR_KBD;
    if (s == SRC_SND) h = HDR_SND;
    return h;
  endfunction

endpackage

// File: rtl/mon_rr_arbiter.sv
// Three-way round-robin arbiter; the pointer names the source tried first.
// With prio_override set, a sound-out request wins outright and does not move the pointer.
module mon_rr_arbiter
  import mon_pkt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       prio_override,
  input  logic       advance,
  input  logic [2:0] adv_grant,
  output logic [2:0] grant
);

  src_e ptr_q, ptr_d;

  // Pick the first requester at or after the pointer, unless sound-out overrides.
  always_comb begin
    logic found;
    int   tmp;
    grant = 3'b000;
    found = 1'b0;
    tmp   = 0;
    if (prio_override && req[SRC_SND]) begin
      grant[SRC_SND] = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        tmp = int'(ptr_q) + k;
        if (tmp > 2) tmp = tmp - 3;
        if (!found && req[tmp]) begin
          grant[tmp] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  // Move the pointer past the source whose packet was just accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (adv_grant[SRC_MIC]) begin
        ptr_d = SRC_KBD;
      end else if (adv_grant[SRC_KBD]) begin
        ptr_d = prio_override ? SRC_MIC : SRC_SND;
      end else if (adv_grant[SRC_SND]) begin
        ptr_d = prio_override ? ptr_q : SRC_MIC;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= SRC_MIC;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mon_tx_scheduler.sv
// Monitor-bus transmit slot scheduler plus microphone record control.
// One packet occupies IDLE (arbitrate), SEND (hold until accepted or timed out), ACK (retire source).
module mon_tx_scheduler
  import mon_pkt_pkg::*;
#(
  parameter int SNDOUT_PRIORITY = 1,
  parameter int TX_TIMEOUT      = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rec_on,
  input  logic        cmd_rec_off,
  output logic        record_start,
  output logic        record_stop,
  output logic        recording,
  input  logic [31:0] mic_data,
  input  logic        mic_valid,
  output logic        mic_retrieved,
  input  logic [31:0] kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_retrieved,
  input  logic        sndout_req,
  output logic [39:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_timeout
);

  localparam bit         PRIO     = (SNDOUT_PRIORITY != 0);
  localparam logic [9:0] TMO_LAST = 10'(TX_TIMEOUT - 1);

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [39:0] tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tmo_q, tmo_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        mic_ret_q, mic_ret_d;
  logic        kbd_ret_q, kbd_ret_d;
  logic        rec_q, rec_d;
  logic        rstart_q, rstart_d;
  logic        rstop_q, rstop_d;
  logic        snd_pend_q, snd_pend_d;
  logic        snd_accept;
  logic        advance;
  logic [2:0]  req;
  logic [2:0]  grant;
  logic [2:0]  src_oh;

  assign req    = {snd_pend_q, kbd_valid, mic_valid & rec_q};
  assign src_oh = 3'b001 << src_q;

  mon_rr_arbiter u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .prio_override(PRIO),
    .advance      (advance),
    .adv_grant    (src_oh),
    .grant        (grant)
  );

  // Record control: stop dominates and always pulses; start only from the not-recording state.
  always_comb begin
    rec_d    = rec_q;
    rstart_d = 1'b0;
    rstop_d  = 1'b0;
    if (cmd_rec_off) begin
      rstop_d = 1'b1;
      rec_d   = 1'b0;
    end else if (cmd_rec_on && !rec_q) begin
      rstart_d = 1'b1;
      rec_d    = 1'b1;
    end
  end

  // Sound-out pending flag: pulses merge, acceptance clears, a same-cycle pulse re-arms.
  always_comb begin
    snd_pend_d = sndout_req | (snd_pend_q & ~snd_accept);
  end

  // Transmit FSM next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    mic_ret_d  = 1'b0;
    kbd_ret_d  = 1'b0;
    advance    = 1'b0;
    snd_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          src_d = onehot_to_src(grant);
          if (grant[SRC_MIC])      tx_data_d = {HDR_MIC, mic_data};
          else if (grant[SRC_KBD]) tx_data_d = {HDR_KBD, kbd_data};
          else                     tx_data_d = {HDR_SND, 32'h0};
          tx_valid_d = 1'b1;
          cnt_d      = 10'd0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          advance    = 1'b1;
          mic_ret_d  = (src_q == SRC_MIC);
          kbd_ret_d  = (src_q == SRC_KBD);
          snd_accept = (src_q == SRC_SND);
          state_d    = ST_ACK;
        end else if (cnt_q == TMO_LAST) begin
          tx_valid_d = 1'b0;
          tmo_d      = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q != 10'h3FF) begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and outputs registered; reset clears everything, dropping any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_MIC;
      tx_data_q  <= 40'h0;
      tx_valid_q <= 1'b0;
      tmo_q      <= 1'b0;
      cnt_q      <= 10'd0;
      mic_ret_q  <= 1'b0;
      kbd_ret_q  <= 1'b0;
      rec_q      <= 1'b0;
      rstart_q   <= 1'b0;
      rstop_q    <= 1'b0;
      snd_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      mic_ret_q  <= mic_ret_d;
      kbd_ret_q  <= kbd_ret_d;
      rec_q      <= rec_d;
      rstart_q   <= rstart_d;
      rstop_q    <= rstop_d;
      snd_pend_q <= snd_pend_d;
    end
  end

  assign record_start  = rstart_q;
  assign record_stop   = rstop_q;
  assign recording     = rec_q;
  assign mic_retrieved = mic_ret_q;
  assign kbd_retrieved = kbd_ret_q;
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign tx_timeout    = tmo_q;

endmodule

// File: tb/tb_mon_tx_scheduler.sv
// Directed bench for mon_tx_scheduler with hand-computed expectations.
module tb_mon_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_rec_on, cmd_rec_off;
  logic        record_start, record_stop, recording;
  logic [31:0] mic_data, kbd_data;
  logic        mic_valid, kbd_valid;
  logic        mic_retrieved, kbd_retrieved;
  logic        sndout_req;
  logic [39:0] tx_data;
  logic        tx_valid, tx_ready, tx_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mon_tx_scheduler #(.SNDOUT_PRIORITY(1), .TX_TIMEOUT(1023)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_rec_on   (cmd_rec_on),
    .cmd_rec_off  (cmd_rec_off),
    .record_start (record_start),
    .record_stop  (record_stop),
    .recording    (recording),
    .mic_data     (mic_data),
    .mic_valid    (mic_valid),
    .mic_retrieved(mic_retrieved),
    .kbd_data     (kbd_data),
    .kbd_valid    (kbd_valid),
    .kbd_retrieved(kbd_retrieved),
    .sndout_req   (sndout_req),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_timeout   (tx_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rec_on();
    cmd_rec_on = 1'b1;
    tick();
    cmd_rec_on = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] m_w [3];
    logic [31:0] k_w [3];
    int  n;
    logic ret_seen;

    cmd_rec_on = 0; cmd_rec_off = 0; mic_data = 0; kbd_data = 0;
    mic_valid = 0; kbd_valid = 0; sndout_req = 0; tx_ready = 0;
    #2;
    do_reset();
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_recording", 64'(recording), 64'd0);
    chk("rst_tx_timeout", 64'(tx_timeout), 64'd0);
    chk("rst_rec_pulses", 64'({record_start, record_stop}), 64'd0);
    tick();

    // Record on, then a redundant record on.
    cmd_rec_on = 1'b1;
    tick();
    cmd_rec_on = 1'b0;
    chk("rec_start_pulse", 64'(record_start), 64'd1);
    chk("recording_set", 64'(recording), 64'd1);
    tick();
    chk("rec_start_one_cycle", 64'(record_start), 64'd0);
    cmd_rec_on = 1'b1;
    tick();
    cmd_rec_on = 1'b0;
    chk("rec_on_again_no_pulse", 64'(record_start), 64'd0);
    chk("recording_held", 64'(recording), 64'd1);

    // Single mic packet with instant ready.
    mic_data = 32'h5AA5_0FF0; mic_valid = 1'b1; tx_ready = 1'b1;
    tick();
    chk("mic_tx_valid", 64'(tx_valid), 64'd1);
    chk("mic_tx_data", 64'(tx_data), 64'h07_5AA5_0FF0);
    chk("mic_ret_early", 64'(mic_retrieved), 64'd0);
    tick();
    chk("mic_ret_pulse", 64'(mic_retrieved), 64'd1);
    chk("mic_tx_valid_drop", 64'(tx_valid), 64'd0);
    mic_valid = 1'b0;
    tick();
    chk("mic_ret_one_cycle", 64'(mic_retrieved), 64'd0);

    // Round-robin alternation from a fresh pointer.
    do_reset();
    rec_on();
    m_w[0] = 32'h1111_0001; m_w[1] = 32'h1111_0002; m_w[2] = 32'h1111_0003;
    k_w[0] = 32'h2222_0001; k_w[1] = 32'h2222_0002; k_w[2] = 32'h2222_0003;
    mic_valid = 1'b1; kbd_valid = 1'b1; tx_ready = 1'b1;
    mic_data = m_w[0]; kbd_data = k_w[0];
    tick();
    chk("rr0_data", 64'(tx_data), {24'h0, 8'h07, m_w[0]});
    tick();
    chk("rr0_ret", 64'({mic_retrieved, kbd_retrieved}), 64'b10);
    mic_data = m_w[1];
    tick();
    chk("rr0_idle", 64'(tx_valid), 64'd0);
    tick();
    chk("rr1_data", 64'(tx_data), {24'h0, 8'h0C, k_w[0]});
    tick();
    chk("rr1_ret", 64'({mic_retrieved, kbd_retrieved}), 64'b01);
    kbd_data = k_w[1];
    tick();
    tick();
    chk("rr2_data", 64'(tx_data), {24'h0, 8'h07, m_w[1]});
    tick();
    chk("rr2_ret", 64'({mic_retrieved, kbd_retrieved}), 64'b10);
    mic_valid = 1'b0; kbd_valid = 1'b0;
    tick();

    // Sound-out priority over a pending kbd word, two merged requests.
    do_reset();
    rec_on();
    mic_data = 32'hCAFE_0001; kbd_data = 32'hBEEF_0002;
    mic_valid = 1'b1; kbd_valid = 1'b1; tx_ready = 1'b0;
    tick();
    chk("snd_mic_first", 64'(tx_data), 64'h07_CAFE_0001);
    sndout_req = 1'b1;
    tick();
    sndout_req = 1'b0;
    tick();
    sndout_req = 1'b1;
    tick();
    sndout_req = 1'b0;
    chk("snd_mic_held", 64'(tx_data), 64'h07_CAFE_0001);
    tx_ready = 1'b1;
    tick();
    chk("snd_mic_ret", 64'(mic_retrieved), 64'd1);
    mic_valid = 1'b0;
    tick();
    tick();
    chk("snd_packet", 64'(tx_data), 64'h03_0000_0000);
    chk("snd_valid", 64'(tx_valid), 64'd1);
    tick();
    chk("snd_no_ret", 64'({mic_retrieved, kbd_retrieved}), 64'd0);
    tick();
    tick();
    chk("snd_then_kbd", 64'(tx_data), 64'h0C_BEEF_0002);
    tick();
    chk("snd_kbd_ret", 64'(kbd_retrieved), 64'd1);
    kbd_valid = 1'b0;
    tick();
    tick();
    chk("snd_merged_single", 64'(tx_valid), 64'd0);

    // Timeout with ready held low, then resend.
    mic_data = 32'h0BAD_F00D; mic_valid = 1'b1; tx_ready = 1'b0;
    tick();
    n = 0;
    ret_seen = 1'b0;
    while (tx_valid && n < 1100) begin
      n++;
      tick();
      if (mic_retrieved) ret_seen = 1'b1;
    end
    chk("tmo_valid_cycles", 64'(n), 64'd1023);
    chk("tmo_sticky_set", 64'(tx_timeout), 64'd1);
    chk("tmo_no_ret", 64'(ret_seen), 64'd0);
    tx_ready = 1'b1;
    tick();
    chk("tmo_resend", 64'(tx_data), 64'h07_0BAD_F00D);
    chk("tmo_resend_valid", 64'(tx_valid), 64'd1);
    tick();
    chk("tmo_resend_ret", 64'(mic_retrieved), 64'd1);
    mic_valid = 1'b0;
    tick();
    chk("tmo_still_sticky", 64'(tx_timeout), 64'd1);

    // Both record commands together while recording: stop wins.
    cmd_rec_on = 1'b1; cmd_rec_off = 1'b1;
    tick();
    cmd_rec_on = 1'b0; cmd_rec_off = 1'b0;
    chk("both_cmd_pulses", 64'({record_start, record_stop}), 64'b01);
    chk("both_cmd_rec", 64'(recording), 64'd0);
    tick();
    chk("stop_one_cycle", 64'(record_stop), 64'd0);
    cmd_rec_off = 1'b1;
    tick();
    cmd_rec_off = 1'b0;
    chk("stop_while_idle", 64'(record_stop), 64'd1);

    // Mic ignored while not recording.
    mic_valid = 1'b1;
    tick();
    tick();
    chk("mic_gated", 64'(tx_valid), 64'd0);
    mic_valid = 1'b0;

    // Reset in the middle of a kbd SEND.
    kbd_data = 32'h1234_5678; kbd_valid = 1'b1; tx_ready = 1'b0;
    tick();
    chk("midsend_valid", 64'(tx_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("midsend_rst_outs", 64'({tx_valid, tx_timeout, recording, mic_retrieved,
                               kbd_retrieved, record_start, record_stop}), 64'd0);
    chk("midsend_rst_data", 64'(tx_data), 64'd0);
    rst_n = 1'b1; kbd_valid = 1'b0;
    tick();
    chk("midsend_no_ret", 64'(kbd_retrieved), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
